// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle mult/multu/div/divu sequencer and owner of the
// architectural HI/LO registers. Also executes mthi/mtlo and raises stall
// while an mfhi/mflo is issued during an iterative operation.
//
// Optional build macro MULDIV_DIVZERO_EN: a div/divu with a zero divisor
// skips the iteration phase and raises the sticky dz flag alongside done.
// When the macro is undefined, dz is tied low and divide by zero runs the
// full latency. Both builds produce the same HI/LO values.
//
// Latency: start accepted at edge N -> done and HI/LO update at edge
// N+WIDTH+2 (N+2 for the divide-by-zero shortcut). FIX takes two cycles:
// a correction phase, then a write phase.

module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mf_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             dz
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    localparam int            CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

`ifdef MULDIV_DIVZERO_EN
    localparam logic DZ_SKIP = 1'b1;
`else
    localparam logic DZ_SKIP = 1'b0;
`endif

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               fix_ph;     // 0: apply sign correction, 1: write HI/LO
    logic               is_div;
    logic               is_signed;
    logic               sign_a;
    logic               sign_b;
    logic               b_zero;
    logic [WIDTH-1:0]   a_raw;      // uncorrected dividend for the b == 0 result
    logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;        // product, or quotient in the low half
    logic [WIDTH-1:0]   rem;        // settled partial remainder (always < divisor)

    // Request decode and operand magnitudes for the capture edge.
    logic               iter_op;
    logic               signed_op;
    logic               div_op;
    logic               mt_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // Per-iteration datapath values.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;     // trial value: remainder with next dividend bit, WIDTH+1 bits
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_nx;

    // Sign-corrected result assembled in the first FIX cycle.
    logic [2*WIDTH-1:0] fix_val;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               accept;
    logic               wr_en;

    assign busy   = (state != S_IDLE);
    assign stall  = mf_req & busy;
    assign accept = (state == S_IDLE) && start;
    assign wr_en  = (state == S_FIX) && fix_ph;

    // Decode the request and form operand magnitudes for signed ops.
    // NOTE: every signal written in an always_comb gets a default first, so no path can leave it holding a value and infer a latch.
    always_comb begin
        iter_op   = 1'b0;
        signed_op = 1'b0;
        div_op    = 1'b0;
        mt_op     = 1'b0;
        case (op)
            OP_MULT:  begin iter_op = 1'b1; signed_op = 1'b1; end
            OP_MULTU: begin iter_op = 1'b1; end
            OP_DIV:   begin iter_op = 1'b1; signed_op = 1'b1; div_op = 1'b1; end
            OP_DIVU:  begin iter_op = 1'b1; div_op = 1'b1; end
            OP_MTHI,
            OP_MTLO:  mt_op = 1'b1;
            default:  ;
        endcase
        a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
        b_mag = (signed_op && b[WIDTH-1]) ? -b : b;
    end

    // One shift-add step (multiply) and one restoring shift-subtract step (divide).
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh  = {rem, acc[WIDTH-1]};
        rem_ge  = (rem_sh >= {1'b0, opnd});
        rem_nx  = rem_ge ? WIDTH'(rem_sh - {1'b0, opnd}) : rem_sh[WIDTH-1:0];
    end

    // Sign correction: product and quotient negated when signs differ,
    // remainder follows the dividend sign; divide by zero yields {a, all ones}.
    always_comb begin
        quo_fix = (is_signed && (sign_a ^ sign_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix = (is_signed && sign_a) ? -rem : rem;
        if (is_div && b_zero)
            fix_val = {a_raw, {WIDTH{1'b1}}};
        else if (is_div)
            fix_val = {rem_fix, quo_fix};
        else if (is_signed && (sign_a ^ sign_b))
            fix_val = -acc;
        else
            fix_val = acc;
    end

    // Sequencer FSM and iterative datapath.
    // NOTE: the datapath registers are reset along with the control state so an aborted operation leaves nothing behind; only state/counter strictly need it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            fix_ph    <= 1'b0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            b_zero    <= 1'b0;
            a_raw     <= '0;
            opnd      <= '0;
            acc       <= '0;
            rem       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                S_IDLE: begin
                    if (start && iter_op) begin
                        is_div    <= div_op;
                        is_signed <= signed_op;
                        sign_a    <= signed_op & a[WIDTH-1];
                        sign_b    <= signed_op & b[WIDTH-1];
                        b_zero    <= (b == '0);
                        a_raw     <= a;
                        cnt       <= '0;
                        fix_ph    <= 1'b0;
                        rem       <= '0;
                        if (div_op) begin
                            opnd <= b_mag;
                            acc  <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            opnd <= a_mag;
                            acc  <= {{WIDTH{1'b0}}, b_mag};
                        end
                        state <= (div_op && (b == '0) && DZ_SKIP) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        rem            <= rem_nx;
                        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], rem_ge};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER)
                        state <= S_FIX;
                end
                S_FIX: begin
                    if (!fix_ph) begin
                        acc    <= fix_val;
                        fix_ph <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Architectural HI/LO: written by mthi/mtlo in IDLE or by a finishing op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr_en) begin
                hi   <= acc[2*WIDTH-1:WIDTH];
                lo   <= acc[WIDTH-1:0];
                done <= 1'b1;
            end else if (accept) begin
                if (op == OP_MTHI) hi <= a;
                if (op == OP_MTLO) lo <= a;
            end
        end
    end

`ifdef MULDIV_DIVZERO_EN
    logic dz_r;

    // Sticky divide-by-zero flag: set with done, cleared by the next accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dz_r <= 1'b0;
        else if (accept && (iter_op || mt_op))
            dz_r <= 1'b0;
        else if (wr_en && is_div && b_zero)
            dz_r <= 1'b1;
    end

    assign dz = dz_r;
`else
    assign dz = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq. Expected HI/LO values
// come from plain 64-bit arithmetic on the operands; latency and dz
// expectations follow the build macro MULDIV_DIVZERO_EN.

module tb_muldiv_seq;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

`ifdef MULDIV_DIVZERO_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [5:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mf_req;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         stall;
    logic         dz;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dz = 1'b0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .mf_req (mf_req),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .dz     (dz)
    );

    always #5 clk = ~clk;

    // Reference: {hi, lo} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] r;
        longint      sx, sy, q, rm;
        r = '0;
        case (o)
            OP_MULT:  r = longint'($signed(x)) * longint'($signed(y));
            OP_MULTU: r = {32'b0, x} * {32'b0, y};
            OP_DIV: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else begin
                    sx = longint'($signed(x));
                    sy = longint'($signed(y));
                    q  = sx / sy;
                    rm = sx % sy;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else        r = {x % y, x / y};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Drive one start pulse across a rising edge; called and returns at a falling edge.
    task automatic issue(input logic [5:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 6'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    // Run one iterative op and check latency, HI/LO hold, result, busy and dz.
    // With chain set it returns on the done cycle so the caller can issue back-to-back.
    task automatic do_iter(input string name, input logic [5:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input bit chain);
        logic [63:0]  exp;
        logic [W-1:0] old_hi, old_lo;
        bit           is_dz, held;
        int           exp_lat, k;
        exp     = ref_result(o, x, y);
        is_dz   = (o == OP_DIV || o == OP_DIVU) && (y == 0);
        exp_lat = (is_dz && DZ_EN) ? 2 : LAT;
        old_hi  = m_hi;
        old_lo  = m_lo;
        issue(o, x, y);
        m_dz = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_rise: got %b want 1", name, busy);
        end
        k    = 0;
        held = 1'b1;
        while (done !== 1'b1 && k < 200) begin
            if (hi !== old_hi || lo !== old_lo) held = 1'b0;
            @(negedge clk);
            k++;
        end
        vectors++;
        if (k != exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles want %0d", name, k, exp_lat);
        end
        vectors++;
        if (!held) begin
            miscompares++;
            $display("FAIL %s hold: hi/lo changed before done", name);
        end
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        if (is_dz && DZ_EN) m_dz = 1'b1;
        vectors++;
        if (hi !== m_hi || lo !== m_lo) begin
            miscompares++;
            $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h (a=%h b=%h)",
                     name, hi, lo, m_hi, m_lo, x, y);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_fall: got %b want 0", name, busy);
        end
        vectors++;
        if (dz !== m_dz) begin
            miscompares++;
            $display("FAIL %s dz: got %b want %b", name, dz, m_dz);
        end
        if (!chain) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s done_pulse: done still %b one cycle later", name, done);
            end
        end
    endtask

    // mthi/mtlo: visible after one edge, no busy, dz cleared.
    task automatic do_mt(input string name, input logic [5:0] o, input logic [W-1:0] x);
        issue(o, x, $urandom);
        if (o == OP_MTHI) m_hi = x;
        else              m_lo = x;
        m_dz = 1'b0;
        vectors++;
        if (hi !== m_hi || lo !== m_lo || busy !== 1'b0 || done !== 1'b0 || dz !== m_dz) begin
            miscompares++;
            $display("FAIL %s: got hi=%h lo=%h busy=%b done=%b dz=%b want hi=%h lo=%h busy=0 done=0 dz=%b",
                     name, hi, lo, busy, done, dz, m_hi, m_lo, m_dz);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        mf_req = 1'b0;
        op     = '0;
        a      = '0;
        b      = '0;
        @(negedge clk);
        vectors++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got hi=%h lo=%h busy=%b done=%b dz=%b stall=%b want all 0",
                     hi, lo, busy, done, dz, stall);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_plan_vectors();
        do_iter("mult_m9_5",  OP_MULT,  -32'sd9, 32'd5, 1'b0);
        do_iter("multu_m9_5", OP_MULTU, -32'sd9, 32'd5, 1'b0);
        do_iter("div_m9_5",   OP_DIV,   -32'sd9, 32'd5, 1'b0);
        do_iter("divu_m9_5",  OP_DIVU,  -32'sd9, 32'd5, 1'b0);
        do_iter("div_9_m5",   OP_DIV,   32'd9, -32'sd5, 1'b0);
        do_mt("mthi_9", OP_MTHI, 32'd9);
        do_mt("mtlo_5", OP_MTLO, 32'd5);
        do_iter("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_iter("mult_min",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);
        do_iter("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_ignored_op();
        logic [W-1:0] old_hi, old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        issue(6'b100000, $urandom, $urandom);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== old_hi || lo !== old_lo) begin
            miscompares++;
            $display("FAIL ignored_op: got busy=%b done=%b hi=%h lo=%h want busy=0 done=0 hi=%h lo=%h",
                     busy, done, hi, lo, old_hi, old_lo);
        end
    endtask

    task automatic test_stall();
        logic [63:0]  exp;
        logic [W-1:0] x, y;
        int           k;
        x = $urandom;
        y = $urandom;
        exp = ref_result(OP_MULT, x, y);
        issue(OP_MULT, x, y);
        k = 0;
        while (done !== 1'b1 && k < 200) begin
            if (k == 5) begin
                start  = 1'b1;
                op     = OP_MTLO;
                a      = ~exp[31:0];
                mf_req = 1'b1;
                #1;
                vectors++;
                if (stall !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_busy: got %b want 1", stall);
                end
            end
            if (k == 6) start = 1'b0;
            @(negedge clk);
            k++;
        end
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        m_dz = 1'b0;
        vectors++;
        if (k != LAT || hi !== m_hi || lo !== m_lo) begin
            miscompares++;
            $display("FAIL stall_result: got lat=%0d hi=%h lo=%h want lat=%0d hi=%h lo=%h",
                     k, hi, lo, LAT, m_hi, m_lo);
        end
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: got %b want 0 after busy falls", stall);
        end
        mf_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen_done;
        issue(OP_MULT, $urandom, $urandom);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: got hi=%h lo=%h busy=%b done=%b dz=%b want all 0",
                     hi, lo, busy, done, dz);
        end
        @(negedge clk);
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        vectors++;
        if (seen_done != 0) begin
            miscompares++;
            $display("FAIL reset_abandon: got %0d busy/done cycles after reset want 0", seen_done);
        end
        do_iter("mult_after_rst", OP_MULT, 32'd1234, -32'sd77, 1'b0);
    endtask

    task automatic test_divzero();
        do_iter("divu_7_0",   OP_DIVU, 32'd7, 32'd0, 1'b0);
        do_iter("div_neg_0",  OP_DIV,  -32'sd100, 32'd0, 1'b0);
        do_iter("mult_clrdz", OP_MULT, 32'd3, 32'd4, 1'b0);
        do_iter("div_0_again", OP_DIV, 32'h8000_0001, 32'd0, 1'b0);
        do_mt("mthi_clrdz", OP_MTHI, 32'hCAFE_F00D);
    endtask

    task automatic test_back_to_back();
        do_iter("b2b_0", OP_DIVU, 32'd1000, 32'd7, 1'b1);
        do_iter("b2b_1", OP_MULT, -32'sd3, -32'sd5, 1'b1);
        do_iter("b2b_2", OP_DIV,  32'd0, 32'd0, 1'b1);
        do_iter("b2b_3", OP_DIV,  -32'sd1000, 32'd7, 1'b0);
    endtask

    function automatic logic [W-1:0] pick_operand(input bit allow_zero);
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = allow_zero ? '0 : 32'd1;
            1:       v = 32'd1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'(($urandom_range(0, 200)));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic test_random();
        logic [W-1:0] x, y;
        logic [5:0]   ops [4];
        ops[0] = OP_MULT;
        ops[1] = OP_MULTU;
        ops[2] = OP_DIV;
        ops[3] = OP_DIVU;
        for (int i = 0; i < 60; i++) begin
            x = pick_operand(1'b1);
            y = pick_operand(1'b1);
            case ($urandom_range(0, 6))
                4:       do_mt("rand_mthi", OP_MTHI, x);
                5:       do_mt("rand_mtlo", OP_MTLO, x);
                6:       test_ignored_op();
                default: do_iter("rand_iter", ops[$urandom_range(0, 3)], x, y, 1'($urandom_range(0, 1)));
            endcase
        end
        @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_plan_vectors();
        test_ignored_op();
        test_stall();
        test_reset_mid();
        test_divzero();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
